// File: rtl/holy_axi_read_arbiter_if.sv
// Bundle of the two cache-side AXI read ports and the shared AXI4 read master port.
// "master" is the arbiter's view; "slave" is the view of everything around it.
interface holy_axi_read_arbiter_if;
    logic [31:0] s0_araddr;
    logic [31:0] s1_araddr;
    logic [7:0]  s0_arlen;
    logic [7:0]  s1_arlen;
    logic        s0_arvalid;
    logic        s1_arvalid;
    logic        s0_arready;
    logic        s1_arready;
    logic [31:0] s0_rdata;
    logic [31:0] s1_rdata;
    logic [1:0]  s0_rresp;
    logic [1:0]  s1_rresp;
    logic        s0_rlast;
    logic        s1_rlast;
    logic        s0_rvalid;
    logic        s1_rvalid;
    logic        s0_rready;
    logic        s1_rready;

    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        input  s0_araddr, s1_araddr, s0_arlen, s1_arlen, s0_arvalid, s1_arvalid,
        output s0_arready, s1_arready,
        output s0_rdata, s1_rdata, s0_rresp, s1_rresp, s0_rlast, s1_rlast,
        output s0_rvalid, s1_rvalid,
        input  s0_rready, s1_rready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output s0_araddr, s1_araddr, s0_arlen, s1_arlen, s0_arvalid, s1_arvalid,
        input  s0_arready, s1_arready,
        input  s0_rdata, s1_rdata, s0_rresp, s1_rresp, s0_rlast, s1_rlast,
        input  s0_rvalid, s1_rvalid,
        output s0_rready, s1_rready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/holy_axi_read_arbiter.sv
// Two-port AXI4 read arbiter (s0 = d-cache, s1 = i-cache) onto one AXI4 read master.
// One burst is owned end to end (AR then all R beats) before the next grant.
module holy_axi_read_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    holy_axi_read_arbiter_if.master        bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [31:0] r_addr;
    logic [7:0]  r_len;

    logic w_any_req;
    logic w_pick;
    logic w_grant_fire;
    logic w_in_addr;
    logic w_in_data;
    logic w_rready;
    logic w_r_done;
    logic w_unused_rid;

    // Contention goes to the port that did not win last; a lone request always wins.
    always_comb begin
        w_pick = bus.s1_arvalid;
        if (bus.s0_arvalid && bus.s1_arvalid) begin
            w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end
    end

    // Gating with rst keeps a requester from seeing an arready that reset then discards.
    assign w_any_req    = bus.s0_arvalid | bus.s1_arvalid;
    assign w_grant_fire = (r_state == S_IDLE) && !rst && w_any_req;
    assign w_in_addr    = (r_state == S_ADDR);
    assign w_in_data    = (r_state == S_DATA);

    assign bus.s0_arready = w_grant_fire & ~w_pick;
    assign bus.s1_arready = w_grant_fire &  w_pick;

    assign bus.m_axi_arvalid = w_in_addr;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arlen   = r_len;
    assign bus.m_axi_arid    = {3'b000, r_grant};
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;

    assign w_rready         = w_in_data & (r_grant ? bus.s1_rready : bus.s0_rready);
    assign bus.m_axi_rready = w_rready;
    assign bus.s0_rvalid    = w_in_data & ~r_grant & bus.m_axi_rvalid;
    assign bus.s1_rvalid    = w_in_data &  r_grant & bus.m_axi_rvalid;

    assign bus.s0_rdata = bus.m_axi_rdata;
    assign bus.s1_rdata = bus.m_axi_rdata;
    assign bus.s0_rresp = bus.m_axi_rresp;
    assign bus.s1_rresp = bus.m_axi_rresp;
    assign bus.s0_rlast = bus.m_axi_rlast;
    assign bus.s1_rlast = bus.m_axi_rlast;

    // Burst end is taken from rlast alone, so any arlen (0..255) passes through untouched.
    assign w_r_done     = bus.m_axi_rvalid & w_rready & bus.m_axi_rlast;
    assign w_unused_rid = ^bus.m_axi_rid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_len        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_fire) begin
                        r_grant <= w_pick;
                        r_addr  <= w_pick ? bus.s1_araddr : bus.s0_araddr;
                        r_len   <= w_pick ? bus.s1_arlen  : bus.s0_arlen;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.m_axi_arready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_holy_axi_read_arbiter.sv
// Bench for holy_axi_read_arbiter: bus-ownership model checked every cycle, end-to-end
// beat scoreboard per requester, directed scenarios and a FIXED_PRIO=1 instance.
module tb_holy_axi_read_arbiter;
    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    holy_axi_read_arbiter_if bus();
    holy_axi_read_arbiter_if bus2();

    holy_axi_read_arbiter #(.FIXED_PRIO(0)) dut    (.clk(clk), .rst(rst),  .bus(bus));
    holy_axi_read_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst2), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int b);
        return a + 32'(b) * 32'd4;
    endfunction

    // Ownership model: who holds the bus, whether its AR has gone out, who won last.
    int          own   = -1;
    bit          sent  = 1'b0;
    int          lastw = 1;
    logic [31:0] taddr = '0;
    logic [7:0]  tlen  = '0;

    function automatic int pick(input bit v0, input bit v1, input int lw);
        if (v0 && v1) return 1 - lw;
        return v1 ? 1 : 0;
    endfunction

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         sq[$];
    ar_t         alog[$];
    int          glog[$];
    int          gcyc[$];
    int          cyc = 0;
    bit          ar_hs[2];
    bit          r_hs = 1'b0;
    bit          req_busy[2];
    logic [31:0] req_addr[2];
    logic [7:0]  req_len[2];
    int          rbeat[2];
    int          rcount[2];
    logic [1:0]  last_resp[2];
    logic        last_rlast[2];
    int          sbeat = 0;
    int          p_arready = 100, p_rvalid = 100, p_rready = 100, p_req = 0;
    bit          toggle_rr = 1'b0;
    int          force_resp = -1;

    task automatic rx(input int p, input logic [31:0] d, input logic l, input logic [1:0] r);
        chk("rx_expected", 32'(req_busy[p]), 1);
        if (req_busy[p]) begin
            chk("rx_data", d, pat(req_addr[p], rbeat[p]));
            chk("rx_last", 32'(l), 32'(rbeat[p] == int'(req_len[p])));
            rbeat[p]++;
            rcount[p]++;
            last_resp[p]  = r;
            last_rlast[p] = l;
            if (rbeat[p] > int'(req_len[p])) req_busy[p] = 1'b0;
        end
    endtask

    always @(negedge clk) begin : mon
        logic [1:0] v;
        logic [1:0] rr;
        int w;
        bit eav;
        bit erdy;
        ar_t a;
        cyc++;
        if (chk_en) begin
            v  = {bus.s1_arvalid, bus.s0_arvalid};
            rr = {bus.s1_rready, bus.s0_rready};
            w  = pick(v[0], v[1], lastw);
            chk("s0_arready", 32'(bus.s0_arready), 32'(own < 0 && !rst && v != 2'b00 && w == 0));
            chk("s1_arready", 32'(bus.s1_arready), 32'(own < 0 && !rst && v != 2'b00 && w == 1));
            eav = (own >= 0) && !sent;
            chk("m_arvalid", 32'(bus.m_axi_arvalid), 32'(eav));
            if (eav) begin
                chk("m_araddr", bus.m_axi_araddr, taddr);
                chk("m_arlen",  32'(bus.m_axi_arlen), 32'(tlen));
                chk("m_arid",   32'(bus.m_axi_arid), 32'(own));
            end
            chk("m_arsize",  32'(bus.m_axi_arsize), 32'h2);
            chk("m_arburst", 32'(bus.m_axi_arburst), 32'h1);
            erdy = (own >= 0) ? (sent && rr[own]) : 1'b0;
            chk("m_rready",  32'(bus.m_axi_rready), 32'(erdy));
            chk("s0_rvalid", 32'(bus.s0_rvalid), 32'(own == 0 && sent && bus.m_axi_rvalid));
            chk("s1_rvalid", 32'(bus.s1_rvalid), 32'(own == 1 && sent && bus.m_axi_rvalid));
            chk("s0_rdata",  bus.s0_rdata, bus.m_axi_rdata);
            chk("s1_rdata",  bus.s1_rdata, bus.m_axi_rdata);
            chk("s0_rresp",  32'(bus.s0_rresp), 32'(bus.m_axi_rresp));
            chk("s1_rresp",  32'(bus.s1_rresp), 32'(bus.m_axi_rresp));
            chk("s0_rlast",  32'(bus.s0_rlast), 32'(bus.m_axi_rlast));
            chk("s1_rlast",  32'(bus.s1_rlast), 32'(bus.m_axi_rlast));

            if (bus.s0_arvalid && bus.s0_arready) begin ar_hs[0] = 1'b1; glog.push_back(0); gcyc.push_back(cyc); end
            if (bus.s1_arvalid && bus.s1_arready) begin ar_hs[1] = 1'b1; glog.push_back(1); gcyc.push_back(cyc); end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                a.id = bus.m_axi_arid; a.addr = bus.m_axi_araddr; a.len = bus.m_axi_arlen;
                sq.push_back(a);
                alog.push_back(a);
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) r_hs = 1'b1;
            if (bus.s0_rvalid && bus.s0_rready) rx(0, bus.s0_rdata, bus.s0_rlast, bus.s0_rresp);
            if (bus.s1_rvalid && bus.s1_rready) rx(1, bus.s1_rdata, bus.s1_rlast, bus.s1_rresp);

            if (rst) begin
                own = -1; sent = 1'b0; lastw = 1;
            end else if (own < 0) begin
                if (v != 2'b00) begin
                    own   = w;
                    taddr = (w == 1) ? bus.s1_araddr : bus.s0_araddr;
                    tlen  = (w == 1) ? bus.s1_arlen  : bus.s0_arlen;
                    sent  = 1'b0;
                end
            end else if (!sent) begin
                if (bus.m_axi_arready) sent = 1'b1;
            end else if (bus.m_axi_rvalid && rr[own] && bus.m_axi_rlast) begin
                lastw = own;
                own   = -1;
            end
        end
    end

    task automatic issue(input int p, input logic [31:0] a, input logic [7:0] l);
        req_busy[p] = 1'b1; req_addr[p] = a; req_len[p] = l; rbeat[p] = 0;
        if (p == 0) begin bus.s0_arvalid = 1'b1; bus.s0_araddr = a; bus.s0_arlen = l; end
        else        begin bus.s1_arvalid = 1'b1; bus.s1_araddr = a; bus.s1_arlen = l; end
    endtask

    function automatic logic [7:0] rand_len();
        int r;
        r = $urandom_range(0, 29);
        if (r == 0) return 8'd255;
        if (r < 8)  return 8'd0;
        return 8'($urandom_range(1, 15));
    endfunction

    task automatic cycle();
        bit was_hs;
        @(posedge clk); #1;
        if (ar_hs[0]) begin ar_hs[0] = 1'b0; bus.s0_arvalid = 1'b0; bus.s0_araddr = $urandom; bus.s0_arlen = 8'($urandom); end
        if (ar_hs[1]) begin ar_hs[1] = 1'b0; bus.s1_arvalid = 1'b0; bus.s1_araddr = $urandom; bus.s1_arlen = 8'($urandom); end
        was_hs = r_hs;
        if (r_hs) begin
            r_hs = 1'b0;
            if (sq.size() > 0) begin
                if (sbeat == int'(sq[0].len)) begin sq.delete(0); sbeat = 0; end
                else sbeat++;
            end
        end
        for (int p = 0; p < 2; p++)
            if (!req_busy[p] && $urandom_range(1, 100) <= p_req) issue(p, $urandom & 32'hFFFF_FFFC, rand_len());
        bus.m_axi_arready = ($urandom_range(1, 100) <= p_arready);
        if (sq.size() > 0) begin
            bus.m_axi_rvalid = (bus.m_axi_rvalid && !was_hs) || ($urandom_range(1, 100) <= p_rvalid);
            bus.m_axi_rdata  = pat(sq[0].addr, sbeat);
            bus.m_axi_rresp  = (force_resp >= 0) ? 2'(force_resp) : 2'(sbeat);
            bus.m_axi_rlast  = (sbeat == int'(sq[0].len));
            bus.m_axi_rid    = sq[0].id;
        end else begin
            bus.m_axi_rvalid = (p_rvalid < 100) && ($urandom_range(0, 7) == 0);
            bus.m_axi_rdata  = $urandom;
            bus.m_axi_rresp  = 2'($urandom);
            bus.m_axi_rlast  = 1'($urandom);
            bus.m_axi_rid    = 4'($urandom);
        end
        if (toggle_rr) bus.s0_rready = ~bus.s0_rready;
        else           bus.s0_rready = ($urandom_range(1, 100) <= p_rready);
        bus.s1_rready = ($urandom_range(1, 100) <= p_rready);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.s0_arvalid = 1'b0; bus.s1_arvalid = 1'b0; bus.m_axi_rvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        sq.delete(); sbeat = 0; r_hs = 1'b0;
        ar_hs[0] = 1'b0; ar_hs[1] = 1'b0; req_busy[0] = 1'b0; req_busy[1] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((req_busy[0] || req_busy[1]) && k < limit) begin cycle(); k++; end
        chk("drain_timeout", {30'b0, req_busy[1], req_busy[0]}, 0);
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base0, base1, g0, a0, k, c0, c1;
        bus.s0_araddr = '0; bus.s1_araddr = '0; bus.s0_arlen = '0; bus.s1_arlen = '0;
        bus.s0_arvalid = 1'b0; bus.s1_arvalid = 1'b0; bus.s0_rready = 1'b0; bus.s1_rready = 1'b0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus2.s0_araddr = 32'hA000; bus2.s1_araddr = 32'hB000; bus2.s0_arlen = '0; bus2.s1_arlen = '0;
        bus2.s0_arvalid = 1'b1; bus2.s1_arvalid = 1'b1; bus2.s0_rready = 1'b1; bus2.s1_rready = 1'b1;
        bus2.m_axi_arready = 1'b1; bus2.m_axi_rid = '0; bus2.m_axi_rdata = 32'h5A5A_5A5A; bus2.m_axi_rresp = '0;
        bus2.m_axi_rlast = 1'b1; bus2.m_axi_rvalid = 1'b1;
        for (int p = 0; p < 2; p++) begin
            ar_hs[p] = 1'b0; req_busy[p] = 1'b0; req_addr[p] = '0; req_len[p] = '0;
            rbeat[p] = 0; rcount[p] = 0; last_resp[p] = '0; last_rlast[p] = 1'b0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; chk_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_m_arvalid", 32'(bus.m_axi_arvalid), 0);
        chk("rst_m_rready",  32'(bus.m_axi_rready), 0);
        chk("rst_s0_rvalid", 32'(bus.s0_rvalid), 0);
        chk("rst_s1_rvalid", 32'(bus.s1_rvalid), 0);

        // Single s0 burst of 4 beats.
        cycle(); issue(0, 32'h0000_1000, 8'd3);
        @(negedge clk);
        chk("t1_s0_arready", 32'(bus.s0_arready), 1);
        chk("t1_s1_arready", 32'(bus.s1_arready), 0);
        cycle(); @(negedge clk);
        chk("t1_arvalid", 32'(bus.m_axi_arvalid), 1);
        chk("t1_araddr",  bus.m_axi_araddr, 32'h0000_1000);
        chk("t1_arlen",   32'(bus.m_axi_arlen), 3);
        chk("t1_arid",    32'(bus.m_axi_arid), 0);
        base0 = rcount[0]; base1 = rcount[1];
        drain(100);
        chk("t1_beats_s0", 32'(rcount[0] - base0), 4);
        chk("t1_beats_s1", 32'(rcount[1] - base1), 0);

        // Simultaneous requests after reset, then both requesting continuously.
        do_reset(1);
        g0 = glog.size(); a0 = alog.size();
        issue(0, 32'h0000_0100, 8'd1);
        issue(1, 32'h0000_2000, 8'd1);
        p_req = 100;
        k = 0;
        while (glog.size() < g0 + 3 && k < 300) begin cycle(); k++; end
        p_req = 0;
        chk("t2_grant_count", 32'(glog.size() >= g0 + 3), 1);
        if (glog.size() >= g0 + 3 && alog.size() >= a0 + 2) begin
            chk("t2_grant0", 32'(glog[g0]), 0);
            chk("t2_grant1", 32'(glog[g0 + 1]), 1);
            chk("t2_grant2", 32'(glog[g0 + 2]), 0);
            chk("t2_gap",    32'(gcyc[g0 + 1] - gcyc[g0]), 4);
            chk("t2_s1_addr", alog[a0 + 1].addr, 32'h0000_2000);
            chk("t2_s1_arid", 32'(alog[a0 + 1].id), 1);
        end
        drain(3000);

        // Address backpressure for 5 cycles, then s0_rready toggling.
        p_arready = 0;
        issue(0, 32'h0000_3000, 8'd3);
        for (int i = 0; i < 5; i++) begin
            cycle(); @(negedge clk);
            chk("t3_arvalid", 32'(bus.m_axi_arvalid), 1);
            chk("t3_araddr",  bus.m_axi_araddr, 32'h0000_3000);
        end
        p_arready = 100; toggle_rr = 1'b1;
        base0 = rcount[0];
        drain(100);
        toggle_rr = 1'b0;
        chk("t3_beats", 32'(rcount[0] - base0), 4);

        // Reset in the middle of an 8-beat burst.
        issue(0, 32'h0000_4000, 8'd7);
        base0 = rcount[0]; k = 0;
        while (rcount[0] - base0 < 2 && k < 50) begin cycle(); k++; end
        chk("t4_reach_beat2", 32'(rcount[0] - base0), 2);
        do_reset(1);
        bus.m_axi_rvalid = 1'b1; bus.s0_rready = 1'b1;
        @(negedge clk);
        chk("t4_m_arvalid",  32'(bus.m_axi_arvalid), 0);
        chk("t4_m_rready",   32'(bus.m_axi_rready), 0);
        chk("t4_s0_rvalid",  32'(bus.s0_rvalid), 0);
        chk("t4_s1_rvalid",  32'(bus.s1_rvalid), 0);
        chk("t4_s0_arready", 32'(bus.s0_arready), 0);
        chk("t4_s1_arready", 32'(bus.s1_arready), 0);
        cycle();
        issue(1, 32'h0000_5000, 8'd0);
        base1 = rcount[1]; a0 = alog.size();
        drain(100);
        chk("t4_s1_beats", 32'(rcount[1] - base1), 1);
        if (alog.size() > a0) begin
            chk("t4_s1_addr", alog[a0].addr, 32'h0000_5000);
            chk("t4_s1_arid", 32'(alog[a0].id), 1);
        end

        // SLVERR on a single-beat s1 burst.
        force_resp = 2;
        issue(1, 32'h0000_6000, 8'd0);
        drain(100);
        force_resp = -1;
        chk("t5_s1_rresp", 32'(last_resp[1]), 2);
        chk("t5_s1_rlast", 32'(last_rlast[1]), 1);
        @(negedge clk);
        chk("t5_idle_arvalid", 32'(bus.m_axi_arvalid), 0);
        chk("t5_idle_rready",  32'(bus.m_axi_rready), 0);

        // Randomised traffic with stray R beats and backpressure everywhere.
        p_arready = 60; p_rvalid = 70; p_rready = 70; p_req = 30;
        repeat (3000) cycle();
        p_req = 0;
        drain(3000);

        // FIXED_PRIO=1: both always requesting, slave always ready, 3-cycle grant period.
        @(posedge clk); #1; rst2 = 1'b0;
        c0 = 0; c1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus2.s0_arready) c0++;
            if (bus2.s1_arready) c1++;
        end
        chk("fp_s0_grants", 32'(c0), 10);
        chk("fp_s1_grants", 32'(c1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
